// File: rtl/auth_responder_v2.sv
// Purpose: USB Type-C authentication responder; decodes one request, runs the backend, returns one response/ERROR frame.
// Latency: error response 2 cycles after the request edge; backend response 1 cycle after be_done_in.
// Backpressure: response held until resp_ack_in; requests arriving while busy are answered later with ERROR Busy.
module auth_responder_v2 #(
  parameter int         MSG_W         = 1000,
  parameter int         NUM_SLOTS     = 8,
  parameter logic [7:0] SUPPORTED_VER = 8'h01,
  parameter int         DIGESTS_TMO   = 135,
  parameter int         CERT_TMO      = 135,
  parameter int         CHAL_TMO      = 635,
  parameter int         TMO_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resp_req_in,
  input  logic [MSG_W-1:0]     auth_msg_resp_in,
  output logic                 resp_req_out,
  output logic [MSG_W-1:0]     auth_msg_resp_out,
  input  logic                 resp_ack_in,
  input  logic [NUM_SLOTS-1:0] slot_mask_in,
  output logic                 be_req_out,
  output logic [1:0]           be_op_out,
  output logic [2:0]           be_slot_out,
  input  logic                 be_done_in,
  input  logic [MSG_W-33:0]    be_payload_in,
  output logic                 busy_out,
  output logic [7:0]           drop_cnt_out
);

  // One-hot state bit positions and encodings.
  localparam int I_IDLE    = 0;
  localparam int I_DECODE  = 1;
  localparam int I_BE_WAIT = 2;
  localparam int I_SEND    = 3;

  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_DECODE  = 4'b0010;
  localparam logic [3:0] S_BE_WAIT = 4'b0100;
  localparam logic [3:0] S_SEND    = 4'b1000;

  // Message types.
  localparam logic [7:0] MT_GET_DIGESTS = 8'h81;
  localparam logic [7:0] MT_GET_CERT    = 8'h82;
  localparam logic [7:0] MT_CHALLENGE   = 8'h83;
  localparam logic [7:0] MT_ERROR       = 8'h7F;

  // ERROR codes.
  localparam logic [7:0] ERR_NONE        = 8'h00;
  localparam logic [7:0] ERR_INVALID     = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED = 8'h02;
  localparam logic [7:0] ERR_BUSY        = 8'h03;
  localparam logic [7:0] ERR_UNSPEC      = 8'h04;

  // Backend operation codes.
  localparam logic [1:0] OP_DIGESTS   = 2'b01;
  localparam logic [1:0] OP_CERT      = 2'b10;
  localparam logic [1:0] OP_CHALLENGE = 2'b11;

  logic [3:0]       state_q;
  logic [3:0]       state_d;

  logic [7:0]       req_ver_q;
  logic [7:0]       req_type_q;
  logic [7:0]       req_p1_q;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [1:0]       be_op_q;
  logic [2:0]       be_slot_q;
  logic [MSG_W-1:0] resp_q;
  logic             busy_pending_q;
  logic [7:0]       drop_cnt_q;

  logic [7:0]       mask8;
  logic [7:0]       dec_code;
  logic [1:0]       dec_op;
  logic [TMO_W-1:0] dec_tmo;
  logic             dec_err;
  logic             tmo_last;
  logic             accept_req;
  logic [7:0]       rsp_p1;

  // Param2 and the request payload carry nothing this responder acts on.
  logic             unused_req_bits;
  assign unused_req_bits = ^auth_msg_resp_in[MSG_W-1:24];

  // ERROR frame: fixed version and type, code in Param1, everything else zero.
  function automatic logic [MSG_W-1:0] err_frame(input logic [7:0] code);
    logic [MSG_W-1:0] f;
    f        = '0;
    f[7:0]   = SUPPORTED_VER;
    f[15:8]  = MT_ERROR;
    f[23:16] = code;
    return f;
  endfunction

  assign accept_req = state_q[I_IDLE] && !busy_pending_q && resp_req_in;
  assign tmo_last   = (tmo_cnt_q == TMO_W'(1));
  assign dec_err    = (dec_code != ERR_NONE);

  // Slot mask widened to 8 bits so Param1[2:0] can index it for any NUM_SLOTS.
  always_comb begin
    mask8                  = '0;
    mask8[NUM_SLOTS-1:0]   = slot_mask_in;
  end

  // Digests report the provisioned-slot mask in Param1; the others echo the request slot.
  always_comb begin
    rsp_p1 = (req_type_q == MT_GET_DIGESTS) ? mask8 : req_p1_q;
  end

  // Header validation in priority order: version, message type, then slot for cert/challenge.
  always_comb begin
    dec_code = ERR_NONE;
    dec_op   = 2'b00;
    dec_tmo  = '0;
    if (req_ver_q != SUPPORTED_VER) begin
      dec_code = ERR_UNSUPPORTED;
    end else begin
      case (req_type_q)
        MT_GET_DIGESTS: begin
          dec_op  = OP_DIGESTS;
          dec_tmo = TMO_W'(DIGESTS_TMO);
        end
        MT_GET_CERT: begin
          dec_op  = OP_CERT;
          dec_tmo = TMO_W'(CERT_TMO);
        end
        MT_CHALLENGE: begin
          dec_op  = OP_CHALLENGE;
          dec_tmo = TMO_W'(CHAL_TMO);
        end
        default: dec_code = ERR_INVALID;
      endcase
      if ((req_type_q == MT_GET_CERT || req_type_q == MT_CHALLENGE) &&
          (req_p1_q >= 8'(NUM_SLOTS) || !mask8[req_p1_q[2:0]])) begin
        dec_code = ERR_INVALID;
      end
    end
  end

  // State register: reset forces IDLE at once, mid-transaction included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a pending Busy is served before any new request is accepted.
  always_comb begin
    state_d = state_q;
    if (state_q[I_IDLE]) begin
      if (busy_pending_q)   state_d = S_SEND;
      else if (resp_req_in) state_d = S_DECODE;
    end else if (state_q[I_DECODE]) begin
      state_d = dec_err ? S_SEND : S_BE_WAIT;
    end else if (state_q[I_BE_WAIT]) begin
      if (be_done_in || tmo_last) state_d = S_SEND;
    end else if (state_q[I_SEND]) begin
      if (resp_ack_in) state_d = S_IDLE;
    end else begin
      state_d = S_IDLE;
    end
  end

  // Outputs come straight from state and datapath registers.
  always_comb begin
    resp_req_out      = state_q[I_SEND];
    be_req_out        = state_q[I_BE_WAIT];
    busy_out          = ~state_q[I_IDLE];
    auth_msg_resp_out = resp_q;
    be_op_out         = be_op_q;
    be_slot_out       = be_slot_q;
    drop_cnt_out      = drop_cnt_q;
  end

  // Capture the header fields of an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ver_q  <= '0;
      req_type_q <= '0;
      req_p1_q   <= '0;
    end else if (accept_req) begin
      req_ver_q  <= auth_msg_resp_in[7:0];
      req_type_q <= auth_msg_resp_in[15:8];
      req_p1_q   <= auth_msg_resp_in[23:16];
    end
  end

  // Backend command and timeout counter; counter clears on done and reaches 0 on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      be_op_q   <= '0;
      be_slot_q <= '0;
      tmo_cnt_q <= '0;
    end else if (state_q[I_DECODE] && !dec_err) begin
      be_op_q   <= dec_op;
      be_slot_q <= (dec_op == OP_DIGESTS) ? 3'd0 : req_p1_q[2:0];
      tmo_cnt_q <= dec_tmo;
    end else if (state_q[I_BE_WAIT]) begin
      tmo_cnt_q <= be_done_in ? '0 : (tmo_cnt_q - TMO_W'(1));
    end
  end

  // Response frame is built on every transition into SEND and held there until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
    end else if (state_q[I_IDLE] && busy_pending_q) begin
      resp_q <= err_frame(ERR_BUSY);
    end else if (state_q[I_DECODE] && dec_err) begin
      resp_q <= err_frame(dec_code);
    end else if (state_q[I_BE_WAIT]) begin
      if (be_done_in) begin
        resp_q <= {be_payload_in, 8'h00, rsp_p1, (req_type_q & 8'h7F), SUPPORTED_VER};
      end else if (tmo_last) begin
        resp_q <= err_frame(ERR_UNSPEC);
      end
    end
  end

  // Requests seen while busy: the first arms a Busy reply, later ones are counted as dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_pending_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else if (!state_q[I_IDLE]) begin
      if (resp_req_in) begin
        if (!busy_pending_q)           busy_pending_q <= 1'b1;
        else if (drop_cnt_q != 8'hFF)  drop_cnt_q     <= drop_cnt_q + 8'd1;
      end
    end else if (busy_pending_q) begin
      // Serving the Busy now; a request arriving in the same cycle re-arms it.
      busy_pending_q <= resp_req_in;
    end
  end

endmodule

// File: tb/tb_auth_responder_v2.sv
// Directed bench for auth_responder_v2: transaction-level model predicts every
// response frame and backend command; a monitor checks them each cycle, and
// hand-computed literal headers/latencies pin the model.
module tb_auth_responder_v2;

  localparam int MSG_W    = 1000;
  localparam int PL_W     = MSG_W - 32;
  localparam int CHAL_TMO = 635;

  logic             clk = 1'b0;
  logic             reset;
  logic             resp_req_in;
  logic [MSG_W-1:0] auth_msg_resp_in;
  logic             resp_req_out;
  logic [MSG_W-1:0] auth_msg_resp_out;
  logic             resp_ack_in;
  logic [7:0]       slot_mask_in;
  logic             be_req_out;
  logic [1:0]       be_op_out;
  logic [2:0]       be_slot_out;
  logic             be_done_in;
  logic [PL_W-1:0]  be_payload_in;
  logic             busy_out;
  logic [7:0]       drop_cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [MSG_W-1:0] exp_q[$];
  logic [1:0]       exp_op;
  logic [2:0]       exp_slot;

  auth_responder_v2 #(.MSG_W(MSG_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .resp_req_in       (resp_req_in),
    .auth_msg_resp_in  (auth_msg_resp_in),
    .resp_req_out      (resp_req_out),
    .auth_msg_resp_out (auth_msg_resp_out),
    .resp_ack_in       (resp_ack_in),
    .slot_mask_in      (slot_mask_in),
    .be_req_out        (be_req_out),
    .be_op_out         (be_op_out),
    .be_slot_out       (be_slot_out),
    .be_done_in        (be_done_in),
    .be_payload_in     (be_payload_in),
    .busy_out          (busy_out),
    .drop_cnt_out      (drop_cnt_out)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [MSG_W-1:0] mk_req(input logic [7:0] v, input logic [7:0] t, input logic [7:0] p1);
    logic [MSG_W-1:0] f;
    f        = '0;
    f[7:0]   = v;
    f[15:8]  = t;
    f[23:16] = p1;
    f[31:24] = 8'h5A;
    f[63:32] = 32'hC0FFEE00;
    return f;
  endfunction

  function automatic logic [7:0] model_code(input logic [MSG_W-1:0] rq, input logic [7:0] mask);
    logic [7:0] t;
    logic [7:0] p;
    t = rq[15:8];
    p = rq[23:16];
    if (rq[7:0] != 8'h01) return 8'h02;
    if (!(t inside {8'h81, 8'h82, 8'h83})) return 8'h01;
    if (t != 8'h81 && (int'(p) >= 8 || mask[p[2:0]] == 1'b0)) return 8'h01;
    return 8'h00;
  endfunction

  function automatic logic [MSG_W-1:0] model_err(input logic [7:0] code);
    logic [MSG_W-1:0] f;
    f       = '0;
    f[31:0] = {8'h00, code, 8'h7F, 8'h01};
    return f;
  endfunction

  function automatic logic [MSG_W-1:0] model_ok(input logic [MSG_W-1:0] rq, input logic [7:0] mask, input logic [PL_W-1:0] pl);
    logic [31:0] h;
    h[7:0]   = 8'h01;
    h[15:8]  = rq[15:8] - 8'h80;
    h[23:16] = (rq[15:8] == 8'h81) ? mask : rq[23:16];
    h[31:24] = 8'h00;
    return {pl, h};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [MSG_W-1:0] rq, input logic [7:0] mask, output logic [7:0] code);
    code             = model_code(rq, mask);
    exp_op           = rq[9:8];
    exp_slot         = (rq[15:8] == 8'h81) ? 3'd0 : rq[18:16];
    slot_mask_in     = mask;
    auth_msg_resp_in = rq;
    resp_req_in      = 1'b1;
    tick();
    resp_req_in = 1'b0;
    chk("decode_busy", 64'(busy_out), 64'd1);
    chk("decode_no_be", 64'(be_req_out), 64'd0);
    chk("decode_no_resp", 64'(resp_req_out), 64'd0);
    if (code != 8'h00) exp_q.push_back(model_err(code));
    tick();
    chk("be_req_after_decode", 64'(be_req_out), 64'(code == 8'h00));
    chk("resp_after_decode", 64'(resp_req_out), 64'(code != 8'h00));
  endtask

  task automatic be_wait(input logic [MSG_W-1:0] rq, input logic [7:0] mask, input int done_after,
                         input int extra, input logic [PL_W-1:0] pl, output int hi);
    bit ended;
    ended = 1'b0;
    hi    = 1;
    if (done_after <= 0) exp_q.push_back(model_err(8'h04));
    for (int k = 1; k <= 5000; k++) begin
      if (k == done_after) begin
        be_done_in    = 1'b1;
        be_payload_in = pl;
        exp_q.push_back(model_ok(rq, mask, pl));
      end
      resp_req_in = (k <= extra);
      tick();
      be_done_in  = 1'b0;
      resp_req_in = 1'b0;
      if (!be_req_out) begin
        ended = 1'b1;
        break;
      end
      hi++;
    end
    chk("be_wait_ended", 64'(ended), 64'd1);
    chk("resp_after_be", 64'(resp_req_out), 64'd1);
  endtask

  task automatic ack();
    int w;
    w = 0;
    while (!resp_req_out && w < 50) begin
      tick();
      w++;
    end
    chk("resp_seen", 64'(resp_req_out), 64'd1);
    resp_ack_in = 1'b1;
    tick();
    resp_ack_in = 1'b0;
    chk("resp_drop_after_ack", 64'(resp_req_out), 64'd0);
    chk("idle_after_ack", 64'(busy_out), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_resp_req"}, 64'(resp_req_out), 64'd0);
    chk({nm, "_be_req"}, 64'(be_req_out), 64'd0);
    chk({nm, "_busy"}, 64'(busy_out), 64'd0);
    chk({nm, "_drop"}, 64'(drop_cnt_out), 64'd0);
    chk({nm, "_op_slot"}, 64'({be_op_out, be_slot_out}), 64'd0);
    chk({nm, "_frame"}, 64'(|auth_msg_resp_out), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (resp_req_out) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: got hdr %h, expected no response", auth_msg_resp_out[31:0]);
        end else begin
          if (auth_msg_resp_out !== exp_q[0]) begin
            n_bad++;
            $display("FAIL resp_frame: got hdr %h pl %h, expected hdr %h pl %h",
                     auth_msg_resp_out[31:0], auth_msg_resp_out[63:32], exp_q[0][31:0], exp_q[0][63:32]);
          end
          if (resp_ack_in) void'(exp_q.pop_front());
        end
      end
      if (be_req_out) begin
        n_cmp++;
        if (be_op_out !== exp_op || be_slot_out !== exp_slot || resp_req_out !== 1'b0) begin
          n_bad++;
          $display("FAIL be_cmd: got op %b slot %0d resp %b, expected op %b slot %0d resp 0",
                   be_op_out, be_slot_out, resp_req_out, exp_op, exp_slot);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]      code;
    int              hi;
    logic [PL_W-1:0] pl;

    reset            = 1'b1;
    resp_req_in      = 1'b0;
    auth_msg_resp_in = '0;
    resp_ack_in      = 1'b0;
    slot_mask_in     = '0;
    be_done_in       = 1'b0;
    be_payload_in    = '0;
    #2 reset = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // GET_CERTIFICATE slot 2, done 5 cycles later
    pl = '0;
    pl[15:0] = 16'hABCD;
    issue(mk_req(8'h01, 8'h82, 8'h02), 8'h04, code);
    chk("t1_op", 64'(be_op_out), 64'h2);
    chk("t1_slot", 64'(be_slot_out), 64'd2);
    be_wait(mk_req(8'h01, 8'h82, 8'h02), 8'h04, 5, 0, pl, hi);
    chk("t1_be_cycles", 64'(hi), 64'd5);
    chk("t1_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00020201);
    chk("t1_payload", 64'(auth_msg_resp_out[63:32]), 64'hABCD);
    chk("t1_payload_hi", 64'(|auth_msg_resp_out[MSG_W-1:64]), 64'd0);
    ack();

    // bad version (with bad type too: version wins)
    issue(mk_req(8'h02, 8'h85, 8'h00), 8'h04, code);
    chk("t2_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00027F01);
    chk("t2_no_be", 64'(be_req_out), 64'd0);
    ack();

    // CHALLENGE timeout
    issue(mk_req(8'h01, 8'h83, 8'h01), 8'h02, code);
    be_wait(mk_req(8'h01, 8'h83, 8'h01), 8'h02, -1, 0, '0, hi);
    chk("t3_be_cycles", 64'(hi), 64'(CHAL_TMO));
    chk("t3_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00047F01);
    ack();

    // CHALLENGE with done on the expiry edge: done wins
    pl = '0;
    pl[31:0] = 32'h5151A5A5;
    issue(mk_req(8'h01, 8'h83, 8'h01), 8'h02, code);
    be_wait(mk_req(8'h01, 8'h83, 8'h01), 8'h02, CHAL_TMO, 0, pl, hi);
    chk("t3b_be_cycles", 64'(hi), 64'(CHAL_TMO));
    chk("t3b_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00010301);
    ack();

    // invalid type, unprovisioned slot, slot beyond NUM_SLOTS
    issue(mk_req(8'h01, 8'h85, 8'h00), 8'hFF, code);
    chk("t4a_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00017F01);
    ack();
    issue(mk_req(8'h01, 8'h82, 8'h05), 8'h04, code);
    chk("t4b_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00017F01);
    ack();
    issue(mk_req(8'h01, 8'h82, 8'h08), 8'hFF, code);
    chk("t4c_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00017F01);
    ack();

    // highest slot, done on the first BE_WAIT cycle
    pl = '0;
    pl[7:0] = 8'h77;
    issue(mk_req(8'h01, 8'h82, 8'h07), 8'h80, code);
    be_wait(mk_req(8'h01, 8'h82, 8'h07), 8'h80, 1, 0, pl, hi);
    chk("t4d_be_cycles", 64'(hi), 64'd1);
    chk("t4d_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00070201);
    ack();

    // three requests during BE_WAIT
    pl = '0;
    pl[15:0] = 16'h1234;
    issue(mk_req(8'h01, 8'h82, 8'h02), 8'h04, code);
    be_wait(mk_req(8'h01, 8'h82, 8'h02), 8'h04, 8, 3, pl, hi);
    exp_q.push_back(model_err(8'h03));
    chk("t5_drop", 64'(drop_cnt_out), 64'd2);
    chk("t5_orig_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00020201);
    ack();
    tick();
    chk("t5_busy_latency", 64'(resp_req_out), 64'd1);
    chk("t5_busy_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00037F01);
    ack();
    chk("t5_drop_hold", 64'(drop_cnt_out), 64'd2);

    // reset in BE_WAIT
    issue(mk_req(8'h01, 8'h83, 8'h01), 8'h02, code);
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk_all_zero("rst_bewait");
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // reset in SEND
    issue(mk_req(8'h03, 8'h81, 8'h00), 8'h03, code);
    tick();
    chk("rst_send_pre", 64'(resp_req_out), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("rst_send");
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // GET_DIGESTS after reset: Param1 replaced by mask, slot forced to 0
    pl = '0;
    pl[15:0] = 16'h0D16;
    issue(mk_req(8'h01, 8'h81, 8'h05), 8'h03, code);
    chk("t7_op", 64'(be_op_out), 64'h1);
    chk("t7_slot", 64'(be_slot_out), 64'd0);
    be_wait(mk_req(8'h01, 8'h81, 8'h05), 8'h03, 2, 0, pl, hi);
    chk("t7_be_cycles", 64'(hi), 64'd2);
    chk("t7_hdr", 64'(auth_msg_resp_out[31:0]), 64'h00030101);
    ack();

    repeat (3) tick();
    chk("all_resp_seen", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
